state_seq_decoder: RTL and testbench
====================================

Name: state_seq_decoder

Overview:
- Receive-side decoder for the 4-state x-driven sequencer: s0 -(x=1)-> s3 -> s1 -> s2 -> s0, with every state holding on x=0.
- Samples a 2-bit state stream and recovers the x bit that produced each transition.
- Flags illegal transitions, tracks lock, and counts advances.
- Sits at the observing end of the link, downstream of the sequencer's state/next_state output.

Parameters:
- CNT_W, 8, width of adv_count; wraps modulo 2^CNT_W.
- LOCK_CNT, 2, number of consecutive legal transitions required to leave FAULT (1..15).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- state_in  input  2  observed sequencer state: s0=00, s1=01, s2=10, s3=11.
- state_vld  input  1  state_in is valid this cycle.
- x_rec  output  1  recovered x for the last accepted transition.
- x_vld  output  1  one-cycle strobe: x_rec is valid.
- err  output  1  one-cycle strobe: illegal transition detected.
- locked  output  1  high while in TRACK.
- adv_count  output  CNT_W  number of recovered x=1 events.
- err_count  output  8  saturating illegal-transition count (see Optional Feature).

Behaviour:
- Successor function: succ(00)=11, succ(11)=01, succ(01)=10, succ(10)=00.
- Classify each (prev, state_in) pair as HOLD (equal), ADV (state_in == succ(prev)), or ILLEGAL (anything else).
- FSM states: HUNT, TRACK, FAULT.
- Reset values: FSM=HUNT; prev=00; x_rec=0; x_vld=0; err=0; locked=0; adv_count=0; err_count=0; lock counter=0.
- HUNT: on state_vld, capture prev<=state_in and go to TRACK. No x_vld or err strobe for this first sample.
- TRACK, state_vld with HOLD: x_rec=0, x_vld=1.
- TRACK, state_vld with ADV: x_rec=1, x_vld=1, adv_count+1 (wraps from all-ones to 0).
- TRACK, state_vld with ILLEGAL: err=1, x_vld=0, go to FAULT, lock counter cleared.
- Every accepted sample in every state updates prev<=state_in.
- FAULT, state_vld with HOLD or ADV: lock counter+1. When the counter reaches LOCK_CNT, go to TRACK.
- FAULT, state_vld with ILLEGAL: err=1, lock counter=0.
- In FAULT: x_vld=0, adv_count frozen, locked=0.
- Latency: outputs are registered; x_vld/x_rec/err assert in the cycle after the sampling edge.
- Strobes are single-cycle; they deassert on any cycle without a qualifying state_vld.
- state_vld low: FSM, prev, counters and lock counter all hold.
- locked = (FSM==TRACK), registered.
- The FAULT->TRACK transition sample itself produces no x_vld. The first x_vld follows the next legal sample.
- Reset asserted mid-stream overrides all inputs that cycle and returns every register to its reset value. The decoder re-enters HUNT.
- Back-to-back state_vld on every cycle is fully supported; there are no bubbles.

Optional Feature:
- Macro STATE_SEQ_DEC_ERRCNT_EN.
- Defined: err_count increments on every err strobe and saturates at 255. It is cleared only by reset.
- Undefined: err_count is tied to 8'd0 and the counter logic is not compiled in. The port list is unchanged.

Decomposition:
- Package state_seq_pkg:
  - state encodings S0..S3 (2-bit);
  - FSM enum {HUNT, TRACK, FAULT};
  - step-class enum {HOLD, ADV, ILLEGAL};
  - successor function.
- Sub-module seq_step_check: combinational classifier, (prev, cur) -> step class. It is reused by the sequencer testbench as a checker.

Test Plan:
- Reset, then state_vld stream 00,00,11,01,10,00 -> first sample produces no strobe; then x_rec 0,1,1,1,1 with x_vld each cycle; adv_count=4; locked=1 from the cycle after the first sample.
- In TRACK with prev=00, present 01 (skip) -> err=1 for one cycle, x_vld=0, locked=0; then 01,10,00 with LOCK_CNT=2 -> TRACK after 2 legal steps, next sample 00 gives x_vld=1, x_rec=0.
- Backward step 11->00 and FAULT re-error -> err strobes each time, lock counter resets; err_count=2 with STATE_SEQ_DEC_ERRCNT_EN, 0 without.
- CNT_W=2, 5 consecutive ADV samples -> adv_count sequence 1,2,3,0,1 (wrap).
- state_vld low for 3 cycles between samples 11 and 01 -> no strobes during the gap; on 01: x_rec=1, x_vld=1.
- Assert reset for 1 cycle while in TRACK with adv_count=3 -> all outputs 0 next cycle, FSM=HUNT; the next sample only captures prev.

Source files
------------

// File: rtl/state_seq_pkg.sv
// Shared types for the x-driven 4-state sequencer decoder: state codes, FSM and step classes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package state_seq_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } dec_state_e;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        ADV     = 2'd1,
        ILLEGAL = 2'd2
    } step_e;

    // Sequencer order on x=1: S0 -> S3 -> S1 -> S2 -> S0.
    function automatic logic [1:0] succ(input logic [1:0] s);
        logic [1:0] r;
        case (s)
            S0:      r = S3;
            S3:      r = S1;
            S1:      r = S2;
            default: r = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_step_check.sv
// Classifies one observed (prev, cur) state pair as HOLD, ADV or ILLEGAL.
// Latency: purely combinational.
// Backpressure: none; evaluated on every pair.
module seq_step_check
    import state_seq_pkg::*;
(
    input  logic [1:0] prev,
    input  logic [1:0] cur,
    output step_e      step_class
);

    // Equal means the sequencer held on x=0; the successor means it advanced on x=1.
    always_comb begin
        step_class = ILLEGAL;
        if (cur == prev) begin
            step_class = HOLD;
        end else if (cur == succ(prev)) begin
            step_class = ADV;
        end
    end

endmodule

// File: rtl/state_seq_decoder.sv
// Recovers x from an observed sequencer state stream, flags illegal steps, tracks lock
// (STATE_SEQ_DEC_ERRCNT_EN compiles in the saturating err_count). Latency: 1 cycle, registered.
// Backpressure: none; accepts a sample on every state_vld cycle, idle cycles hold all state.
module state_seq_decoder
    import state_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       state_in,
    input  logic             state_vld,
    output logic             x_rec,
    output logic             x_vld,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] adv_count,
    output logic [7:0]       err_count
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    dec_state_e       fsm_q, fsm_nxt;
    logic [1:0]       prev_q, prev_nxt;
    logic             x_rec_nxt, x_vld_nxt, err_nxt;
    logic [CNT_W-1:0] adv_nxt;
    logic [3:0]       lock_q, lock_nxt;
    step_e            step_class;

    seq_step_check u_step_check (
        .prev       (prev_q),
        .cur        (state_in),
        .step_class (step_class)
    );

    // State register plus registered strobes and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= HUNT;
            prev_q    <= S0;
            x_rec     <= 1'b0;
            x_vld     <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
            adv_count <= '0;
            lock_q    <= 4'd0;
        end else begin
            fsm_q     <= fsm_nxt;
            prev_q    <= prev_nxt;
            x_rec     <= x_rec_nxt;
            x_vld     <= x_vld_nxt;
            err       <= err_nxt;
            locked    <= (fsm_nxt == TRACK);
            adv_count <= adv_nxt;
            lock_q    <= lock_nxt;
        end
    end

    // Next-state and next-output decode; nothing moves without state_vld.
    always_comb begin
        fsm_nxt   = fsm_q;
        prev_nxt  = prev_q;
        x_rec_nxt = x_rec;
        x_vld_nxt = 1'b0;
        err_nxt   = 1'b0;
        adv_nxt   = adv_count;
        lock_nxt  = lock_q;
        if (state_vld) begin
            prev_nxt = state_in;
            case (fsm_q)
                HUNT: begin
                    // First sample only establishes the reference state.
                    fsm_nxt = TRACK;
                end
                TRACK: begin
                    case (step_class)
                        HOLD: begin
                            x_rec_nxt = 1'b0;
                            x_vld_nxt = 1'b1;
                        end
                        ADV: begin
                            x_rec_nxt = 1'b1;
                            x_vld_nxt = 1'b1;
                            adv_nxt   = adv_count + CNT_W'(1);
                        end
                        default: begin
                            err_nxt  = 1'b1;
                            fsm_nxt  = FAULT;
                            lock_nxt = 4'd0;
                        end
                    endcase
                end
                FAULT: begin
                    if (step_class == ILLEGAL) begin
                        err_nxt  = 1'b1;
                        lock_nxt = 4'd0;
                    end else if (lock_q + 4'd1 >= LOCK_TGT) begin
                        // Relock; this sample itself produces no x strobe.
                        fsm_nxt  = TRACK;
                        lock_nxt = 4'd0;
                    end else begin
                        lock_nxt = lock_q + 4'd1;
                    end
                end
                default: begin
                    fsm_nxt = HUNT;
                end
            endcase
        end
    end

`ifdef STATE_SEQ_DEC_ERRCNT_EN
    logic [7:0] err_count_q;

    // Saturating count of err strobes, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= 8'd0;
        end else if (err_nxt && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_state_seq_decoder.sv
// Scoreboard bench for state_seq_decoder: a behavioural model queues expected outputs per
// driven cycle and the queue is drained one cycle later on the falling edge. A second
// instance with CNT_W=2 checks adv_count wrap on the same stimulus.
module tb_state_seq_decoder;

    localparam int LOCK_CNT = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_in = 2'b00;
    logic       state_vld = 1'b0;

    logic       x_rec, x_vld, err, locked;
    logic [7:0] adv_count, err_count;
    logic       w2_x_rec, w2_x_vld, w2_err, w2_locked;
    logic [1:0] w2_adv_count;
    logic [7:0] w2_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       x_rec;
        logic       x_vld;
        logic       err;
        logic       locked;
        logic [7:0] adv8;
        logic [1:0] adv2;
        logic [7:0] errc;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    int         m_mode;      // 0 hunt, 1 track, 2 fault
    logic [1:0] m_prev;
    logic       m_xrec, m_xvld, m_err, m_locked;
    logic [7:0] m_adv8, m_errc;
    logic [1:0] m_adv2;
    int         m_lk;
    logic [1:0] succ_tbl [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    state_seq_decoder #(.CNT_W(8), .LOCK_CNT(LOCK_CNT)) dut (
        .clock     (clock),
        .reset     (reset),
        .state_in  (state_in),
        .state_vld (state_vld),
        .x_rec     (x_rec),
        .x_vld     (x_vld),
        .err       (err),
        .locked    (locked),
        .adv_count (adv_count),
        .err_count (err_count)
    );

    state_seq_decoder #(.CNT_W(2), .LOCK_CNT(LOCK_CNT)) dut_w2 (
        .clock     (clock),
        .reset     (reset),
        .state_in  (state_in),
        .state_vld (state_vld),
        .x_rec     (w2_x_rec),
        .x_vld     (w2_x_vld),
        .err       (w2_err),
        .locked    (w2_locked),
        .adv_count (w2_adv_count),
        .err_count (w2_err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic vld, input logic [1:0] st);
        if (rst) begin
            m_mode = 0; m_prev = 2'b00; m_xrec = 1'b0; m_xvld = 1'b0; m_err = 1'b0;
            m_locked = 1'b0; m_adv8 = 8'd0; m_adv2 = 2'd0; m_errc = 8'd0; m_lk = 0;
            return;
        end
        m_xvld = 1'b0;
        m_err  = 1'b0;
        if (vld) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (st == m_prev) begin
                    m_xvld = 1'b1; m_xrec = 1'b0;
                end else if (st == succ_tbl[m_prev]) begin
                    m_xvld = 1'b1; m_xrec = 1'b1;
                    m_adv8 = m_adv8 + 8'd1;
                    m_adv2 = m_adv2 + 2'd1;
                end else begin
                    m_err = 1'b1; m_mode = 2; m_lk = 0;
                end
            end else begin
                if (st == m_prev || st == succ_tbl[m_prev]) begin
                    m_lk++;
                    if (m_lk == LOCK_CNT) begin
                        m_mode = 1; m_lk = 0;
                    end
                end else begin
                    m_err = 1'b1; m_lk = 0;
                end
            end
            m_prev = st;
        end
`ifdef STATE_SEQ_DEC_ERRCNT_EN
        if (m_err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
`endif
        m_locked = (m_mode == 1);
    endtask

    // One cycle: compare last cycle's expectation, then drive and queue the next one.
    task automatic step(input logic rst, input logic vld, input logic [1:0] st);
        exp_t e;
        @(negedge clock);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("x_vld",     {31'd0, x_vld},      {31'd0, e.x_vld});
            check("x_rec",     {31'd0, x_rec},      {31'd0, e.x_rec});
            check("err",       {31'd0, err},        {31'd0, e.err});
            check("locked",    {31'd0, locked},     {31'd0, e.locked});
            check("adv_count", {24'd0, adv_count},  {24'd0, e.adv8});
            check("err_count", {24'd0, err_count},  {24'd0, e.errc});
            check("w2_adv",    {30'd0, w2_adv_count}, {30'd0, e.adv2});
            check("w2_x_vld",  {31'd0, w2_x_vld},   {31'd0, e.x_vld});
        end
        reset = rst;
        state_vld = vld;
        state_in = st;
        model(rst, vld, st);
        sb.push_back('{x_rec: m_xrec, x_vld: m_xvld, err: m_err, locked: m_locked,
                       adv8: m_adv8, adv2: m_adv2, errc: m_errc});
    endtask

    task automatic send_seq(input logic [1:0] s [$]);
        foreach (s[i]) step(1'b0, 1'b1, s[i]);
    endtask

    initial begin
        logic [1:0] seq [$];

        // Reset for two cycles.
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);

        // Lock and recover x: 0,1,1,1,1.
        seq = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
        send_seq(seq);

        // Skip 00->01, then relock after two legal steps.
        seq = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        send_seq(seq);

        // Backward step 11->00, re-error in FAULT, then relock.
        seq = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01};
        send_seq(seq);

        // Five consecutive advances (narrow counter wraps).
        seq = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
        send_seq(seq);

        // Gap of three idle cycles between 11 and 01.
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b11);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b10);
        step(1'b0, 1'b1, 2'b01);

        // Reset mid-stream overrides a valid sample; next sample only captures.
        step(1'b1, 1'b1, 2'b10);
        seq = '{2'b10, 2'b00, 2'b11};
        send_seq(seq);

        // Random stream with occasional resets.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)));
        end

        // Alternating illegal steps push err_count toward saturation.
        step(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b00);

        // Flush last expectation.
        step(1'b0, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
